// File: rtl/pad_pkg.sv
// Shared definitions for the NES/SNES pad poller: FSM states, button bit indices
// and a microsecond-to-cycle helper.
package pad_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_LOW    = 3'd2,
    S_HIGH   = 3'd3,
    S_UPDATE = 3'd4
  } pad_state_t;

  // SNES serial order
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  // NES serial order
  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  function automatic int us_to_cyc(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/pad_shift_channel.sv
// One pad's data path: DATA synchroniser, inverting shift register, connect
// detection and frame-to-frame press/release edge detection.
module pad_shift_channel #(
  parameter int NUM_BITS = 16,
  parameter int BIT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data,
  input  logic                sample,
  input  logic [BIT_W-1:0]    bit_idx,
  input  logic                update,
  output logic [NUM_BITS-1:0] buttons,
  output logic [NUM_BITS-1:0] pressed,
  output logic [NUM_BITS-1:0] released,
  output logic                connected
);

  logic [1:0]          sync_q;
  logic [NUM_BITS-1:0] shift_q;
  logic [NUM_BITS-1:0] new_btn;
  logic                raw_all_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], data};
    end
  end

  // Buttons are active-low on the wire; store 1 = pressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (sample) begin
      shift_q[bit_idx] <= ~sync_q[1];
    end
  end

  // A pulled-down line with no pad reads all-low, i.e. every stored bit set
  assign raw_all_low = &shift_q;
  assign new_btn     = raw_all_low ? '0 : shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buttons   <= '0;
      pressed   <= '0;
      released  <= '0;
      connected <= 1'b0;
    end else if (update) begin
      buttons   <= new_btn;
      pressed   <= new_btn & ~buttons;
      released  <= ~new_btn & buttons;
      connected <= ~raw_all_low;
    end else begin
      pressed   <= '0;
      released  <= '0;
    end
  end

endmodule

// File: rtl/multi_pad_controller.sv
// Polls NUM_PADS serial game pads on a shared LATCH/PULSE pair and publishes
// per-frame button state, press/release strobes and connect status.
module multi_pad_controller
  import pad_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 16,
  parameter int CLK_HZ   = 50_000_000,
  parameter int POLL_HZ  = 60,
  parameter int LATCH_US = 12,
  parameter int PULSE_US = 6
) (
  input  logic                         CLOCK,
  input  logic                         RESET_N,
  input  logic                         ENABLE,
  input  logic [NUM_PADS-1:0]          DATA,
  output logic                         LATCH,
  output logic                         PULSE,
  output logic [NUM_PADS*NUM_BITS-1:0] BUTTONS,
  output logic [NUM_PADS*NUM_BITS-1:0] PRESSED,
  output logic [NUM_PADS*NUM_BITS-1:0] RELEASED,
  output logic [NUM_PADS-1:0]          CONNECTED,
  output logic                         VALID,
  output logic                         BUSY,
  output pad_state_t                   STATE_DBG
);

  localparam int POLL_CYC  = CLK_HZ / POLL_HZ;
  localparam int LATCH_CYC = us_to_cyc(CLK_HZ, LATCH_US);
  localparam int HALF_CYC  = us_to_cyc(CLK_HZ, PULSE_US);
  localparam int FRAME_CYC = LATCH_CYC + 2 * HALF_CYC * NUM_BITS + 1;
  localparam int POLL_W    = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int PHASE_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int BIT_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYC - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYC - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_CYC - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(NUM_BITS - 1);

  if (FRAME_CYC >= POLL_CYC) begin : g_bad_timing
    $error("multi_pad_controller: frame of %0d cycles does not fit poll period of %0d", FRAME_CYC, POLL_CYC);
  end
  if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_pads
    $error("multi_pad_controller: NUM_PADS must be 1..4, got %0d", NUM_PADS);
  end

  pad_state_t          state_q, state_n;
  logic [POLL_W-1:0]   poll_q;
  logic [PHASE_W-1:0]  phase_q;
  logic [BIT_W-1:0]    bit_q;
  logic                tick;
  logic                sample;
  logic                update;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      poll_q <= '0;
    end else if (poll_q == POLL_LAST) begin
      poll_q <= '0;
    end else begin
      poll_q <= poll_q + POLL_W'(1);
    end
  end

  assign tick = (poll_q == POLL_LAST);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Ticks that land while a frame runs or ENABLE is low are simply ignored
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:   if (tick && ENABLE) state_n = S_LATCH;
      S_LATCH:  if (phase_q == LATCH_LAST) state_n = S_LOW;
      S_LOW:    if (phase_q == HALF_LAST) state_n = S_HIGH;
      S_HIGH:   if (phase_q == HALF_LAST) state_n = (bit_q == BIT_LAST) ? S_UPDATE : S_LOW;
      S_UPDATE: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q <= '0;
    end else if (state_n != state_q) begin
      phase_q <= '0;
    end else if (state_q == S_LATCH || state_q == S_LOW || state_q == S_HIGH) begin
      phase_q <= phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_q <= '0;
    end else if (state_q == S_IDLE) begin
      bit_q <= '0;
    end else if (state_q == S_HIGH && state_n == S_LOW) begin
      bit_q <= bit_q + BIT_W'(1);
    end
  end

  // Pins are registered from the next state so they switch cleanly with the FSM
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      LATCH <= 1'b0;
      PULSE <= 1'b1;
      VALID <= 1'b0;
    end else begin
      LATCH <= (state_n == S_LATCH);
      PULSE <= (state_n != S_LOW);
      VALID <= (state_q == S_UPDATE);
    end
  end

  assign sample    = (state_q == S_LOW) && (phase_q == HALF_LAST);
  assign update    = (state_q == S_UPDATE);
  assign BUSY      = (state_q != S_IDLE);
  assign STATE_DBG = state_q;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    pad_shift_channel #(
      .NUM_BITS (NUM_BITS),
      .BIT_W    (BIT_W)
    ) u_chan (
      .clk       (CLOCK),
      .rst_n     (RESET_N),
      .data      (DATA[p]),
      .sample    (sample),
      .bit_idx   (bit_q),
      .update    (update),
      .buttons   (BUTTONS[p*NUM_BITS +: NUM_BITS]),
      .pressed   (PRESSED[p*NUM_BITS +: NUM_BITS]),
      .released  (RELEASED[p*NUM_BITS +: NUM_BITS]),
      .connected (CONNECTED[p])
    );
  end

endmodule
